// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback mux, forwarding copy,
// HALT state tracking and saturating retired/cycle counters.
module writeback_stage #(
    parameter int unsigned NB     = 32,
    parameter int unsigned NB_REG = 5,
    parameter int unsigned NB_CNT = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic              i_valid,
    input  logic [NB-1:0]     i_data_memory,
    input  logic [NB-1:0]     i_alu_result,
    input  logic [NB-1:0]     i_pc_plus_8,
    input  logic [NB_REG-1:0] i_rd_addr,
    input  logic              i_reg_write,
    input  logic              i_mem_to_reg,
    input  logic              i_jal_link,
    input  logic              i_halt,
    output logic [NB-1:0]     o_wb_data,
    output logic [NB_REG-1:0] o_wb_addr,
    output logic              o_wb_enable,
    output logic              o_fwd_valid,
    output logic [NB_REG-1:0] o_fwd_addr,
    output logic [NB-1:0]     o_fwd_data,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_retired_count,
    output logic [NB_CNT-1:0] o_cycle_count
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t            state;
    logic              wb_valid;
    logic [NB-1:0]     wb_data_memory;
    logic [NB-1:0]     wb_alu_result;
    logic [NB-1:0]     wb_pc_plus_8;
    logic [NB_REG-1:0] wb_rd_addr;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic              wb_jal_link;
    logic              wb_halt;
    logic [NB_CNT-1:0] retired_count;
    logic [NB_CNT-1:0] cycle_count;
    logic              load;

    // The pipeline only advances on a debug step while still running
    assign load = i_step && (state == RUN);

    // MEM/WB register, run/halt state and saturating counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= RUN;
            wb_valid       <= 1'b0;
            wb_data_memory <= '0;
            wb_alu_result  <= '0;
            wb_pc_plus_8   <= '0;
            wb_rd_addr     <= '0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_jal_link    <= 1'b0;
            wb_halt        <= 1'b0;
            retired_count  <= '0;
            cycle_count    <= '0;
        end else if (load) begin
            wb_valid       <= i_valid;
            wb_data_memory <= i_data_memory;
            wb_alu_result  <= i_alu_result;
            wb_pc_plus_8   <= i_pc_plus_8;
            wb_rd_addr     <= i_rd_addr;
            wb_reg_write   <= i_reg_write;
            wb_mem_to_reg  <= i_mem_to_reg;
            wb_jal_link    <= i_jal_link;
            wb_halt        <= i_halt;
            if (cycle_count != '1) begin
                cycle_count <= cycle_count + NB_CNT'(1);
            end
            if (i_valid && (retired_count != '1)) begin
                retired_count <= retired_count + NB_CNT'(1);
            end
            if (i_valid && i_halt) begin
                state <= HALTED;
            end
        end
    end

    // Writeback select: link address beats load data beats ALU result
    always_comb begin
        o_wb_data = wb_alu_result;
        if (wb_jal_link) begin
            o_wb_data = wb_pc_plus_8;
        end else if (wb_mem_to_reg) begin
            o_wb_data = wb_data_memory;
        end
    end

    // Bubbles, HALT and writes to x0 never reach the register file
    assign o_wb_enable = wb_valid && wb_reg_write && !wb_halt && (wb_rd_addr != '0);
    assign o_wb_addr   = wb_rd_addr;

    assign o_fwd_valid = o_wb_enable;
    assign o_fwd_addr  = o_wb_addr;
    assign o_fwd_data  = o_wb_data;

    assign o_halted        = (state == HALTED);
    assign o_retired_count = retired_count;
    assign o_cycle_count   = cycle_count;

endmodule
